// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that shares one binary-to-Gray converter among NREQ
// requesters and returns the result, tagged with the requester index, on a
// valid/ready port.
module gray_conv_arbiter #(
    parameter  int WIDTH = 4,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] bin_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_gray,
    output logic [IDW-1:0]        out_id,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int unsigned NR = NREQ;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   last_id;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] bin_q;
    logic [IDW-1:0]   win_id;
    logic [WIDTH-1:0] win_bin;
    logic             win_found;
    int unsigned      rr_idx;
    logic [WIDTH-1:0] bin_arr [NREQ];

    // Split the flattened input bus into one word per requester
    always_comb begin
        for (int unsigned k = 0; k < NR; k++) begin
            bin_arr[k] = bin_in[k*WIDTH +: WIDTH];
        end
    end

    // Round-robin search starting just after the last served requester
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_bin   = '0;
        rr_idx    = 0;
        for (int unsigned i = 1; i <= NR; i++) begin
            rr_idx = (32'(last_id) + i) % NR;
            if (!win_found && req[IDW'(rr_idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(rr_idx);
                win_bin   = bin_arr[IDW'(rr_idx)];
            end
        end
    end

    // Next-state decode; requests are only looked at in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = CONV;
            CONV:    state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register with busy flopped alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Grant, capture, convert and hold the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            out_valid <= 1'b0;
            out_gray  <= '0;
            out_id    <= '0;
            bin_q     <= '0;
            id_q      <= '0;
            last_id   <= IDW'(NREQ - 1);
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt[win_id] <= 1'b1;
                        bin_q       <= win_bin;
                        id_q        <= win_id;
                        last_id     <= win_id;
                    end
                end
                CONV: begin
                    out_gray  <= bin_q ^ (bin_q >> 1);
                    out_id    <= id_q;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
